// File: rtl/pwm_ctrl_if.sv
// SPI pin bundle between the host (master) and pwm_ctrl (slave).
interface pwm_ctrl_if;
  logic nCS;
  logic SCK;
  logic MOSI;

  modport master (output nCS, output SCK, output MOSI);
  modport slave  (input  nCS, input  SCK, input  MOSI);
endinterface

// File: rtl/pwm_ctrl.sv
// SPI-programmable multi-channel PWM with double-buffered period/thresholds.
// Optional per-channel output polarity register: define PWM_CTRL_POLARITY_EN.
module pwm_ctrl #(
  parameter int pwm_width = 16,
  parameter int num_pwm   = 12
) (
  input  logic               clk,
  input  logic               reset_n,
  pwm_ctrl_if.slave          spi,
  output logic [num_pwm-1:0] pwm_out,
  output logic               period_start,
  output logic               frame_err
);
  localparam int DW  = ((pwm_width + 7) / 8) * 8;
  localparam int FW  = 8 + DW;
  localparam int BCW = $clog2(FW + 2);
  localparam logic [BCW-1:0]       BC_FULL = BCW'(FW);
  localparam logic [BCW-1:0]       BC_SAT  = BCW'(FW + 1);
  localparam logic [BCW-1:0]       BC_ONE  = BCW'(1);
  localparam logic [pwm_width-1:0] CNT_ONE = pwm_width'(1);
`ifdef PWM_CTRL_POLARITY_EN
  localparam int MAX_ADDR = num_pwm + 1;
`else
  localparam int MAX_ADDR = num_pwm;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  // Pin order in the synchroniser vectors: {nCS, SCK, MOSI}
  logic [2:0] pin_s1_q, pin_s1_d, pin_s2_q, pin_s2_d;
  logic [1:0] edge_prev_q, edge_prev_d;
  logic       ncs_fall, ncs_rise, sck_rise, mosi_bit;

  always_comb begin
    pin_s1_d    = {spi.nCS, spi.SCK, spi.MOSI};
    pin_s2_d    = pin_s1_q;
    edge_prev_d = pin_s2_q[2:1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pin_s1_q    <= 3'b100;
      pin_s2_q    <= 3'b100;
      edge_prev_q <= 2'b10;
    end else begin
      pin_s1_q    <= pin_s1_d;
      pin_s2_q    <= pin_s2_d;
      edge_prev_q <= edge_prev_d;
    end
  end

  assign ncs_fall = edge_prev_q[1] & ~pin_s2_q[2];
  assign ncs_rise = ~edge_prev_q[1] & pin_s2_q[2];
  assign sck_rise = pin_s2_q[1] & ~edge_prev_q[0];
  assign mosi_bit = pin_s2_q[0];

  state_t            state_q, state_d;
  logic [BCW-1:0]    bitcnt_q, bitcnt_d;
  logic [FW-1:0]     shreg_q, shreg_d;
  logic [7:0]        addr;
  logic [pwm_width-1:0] wdata;
  logic              addr_ok;
  logic              commit_wr;

  assign addr    = shreg_q[FW-1 -: 8];
  assign wdata   = shreg_q[pwm_width-1:0];
  assign addr_ok = ({1'b0, addr} <= 9'(MAX_ADDR));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ncs_fall) state_d = SHIFT;
      SHIFT:   if (ncs_rise) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Only an exact-length frame to a mapped address is written; all else is flagged.
  always_comb begin
    commit_wr = 1'b0;
    frame_err = 1'b0;
    if (state_q == COMMIT) begin
      if (bitcnt_q == BC_FULL && addr_ok) commit_wr = 1'b1;
      else                                frame_err = 1'b1;
    end
  end

  always_comb begin
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    if (state_q == IDLE && ncs_fall) begin
      bitcnt_d = '0;
      shreg_d  = '0;
    end else if (state_q == SHIFT && sck_rise) begin
      shreg_d = {shreg_q[FW-2:0], mosi_bit};
      if (bitcnt_q != BC_SAT) bitcnt_d = bitcnt_q + BC_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bitcnt_q <= '0;
      shreg_q  <= '0;
    end else begin
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
    end
  end

  logic [pwm_width-1:0] cnt_q, cnt_d;
  logic [pwm_width-1:0] per_sh_q, per_sh_d, per_act_q, per_act_d;
  logic [pwm_width-1:0] thr_sh_q  [num_pwm];
  logic [pwm_width-1:0] thr_sh_d  [num_pwm];
  logic [pwm_width-1:0] thr_act_q [num_pwm];
  logic [pwm_width-1:0] thr_act_d [num_pwm];
  logic [num_pwm-1:0]   pol_act;
  logic [num_pwm-1:0]   pwm_out_q, pwm_out_d;
  logic                 period_start_q, period_start_d;
  logic                 wrap;

  assign wrap = (cnt_q == per_act_q);

  // Shadow writes land before the wrap copy, so a commit on the wrap cycle takes effect.
  always_comb begin
    thr_sh_d = thr_sh_q;
    per_sh_d = per_sh_q;
    if (commit_wr) begin
      for (int i = 0; i < num_pwm; i++)
        if (addr == 8'(i)) thr_sh_d[i] = wdata;
      if (addr == 8'(num_pwm)) per_sh_d = wdata;
    end
    thr_act_d      = wrap ? thr_sh_d : thr_act_q;
    per_act_d      = wrap ? per_sh_d : per_act_q;
    cnt_d          = wrap ? '0 : cnt_q + CNT_ONE;
    period_start_d = wrap;
    for (int i = 0; i < num_pwm; i++)
      pwm_out_d[i] = (cnt_q < thr_act_q[i]) ^ pol_act[i];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q          <= '0;
      per_sh_q       <= '1;
      per_act_q      <= '1;
      thr_sh_q       <= '{default: '0};
      thr_act_q      <= '{default: '0};
      pwm_out_q      <= '0;
      period_start_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      per_sh_q       <= per_sh_d;
      per_act_q      <= per_act_d;
      thr_sh_q       <= thr_sh_d;
      thr_act_q      <= thr_act_d;
      pwm_out_q      <= pwm_out_d;
      period_start_q <= period_start_d;
    end
  end

`ifdef PWM_CTRL_POLARITY_EN
  logic [num_pwm-1:0] pol_sh_q, pol_sh_d, pol_act_q, pol_act_d;

  always_comb begin
    pol_sh_d = pol_sh_q;
    if (commit_wr && addr == 8'(num_pwm + 1)) pol_sh_d = wdata[num_pwm-1:0];
    pol_act_d = wrap ? pol_sh_d : pol_act_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pol_sh_q  <= '0;
      pol_act_q <= '0;
    end else begin
      pol_sh_q  <= pol_sh_d;
      pol_act_q <= pol_act_d;
    end
  end

  assign pol_act = pol_act_q;
`else
  assign pol_act = '0;
`endif

  assign pwm_out      = pwm_out_q;
  assign period_start = period_start_q;
endmodule
